// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// register count and the sweep/run state encoding.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int regCount(input int addrW);
    return 2 ** addrW;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-input round-robin arbiter: a lone request wins outright, a tie goes to
// the pointer, and every grant moves the pointer to the other requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Granting requester 0 hands priority to requester 1 and vice versa.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: clears every register after reset, then
// merges two valid/ready write requesters into one registered write port.
//
// Handshake: a request transfers in any cycle where req_valid[i] and
// req_ready[i] are both high; a requester not granted keeps valid, addr and
// data stable until it is, and req_ready never depends on anything but
// req_valid, the priority pointer and the current state.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              init_done,
  output state_t            dbgState
);

  // One extra counter bit lets the sweep run one step past the last
  // register, which is the cycle spent before entering RUN.
  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_REG = CNT_W'(regCount(ADDR_W) - 1);

  state_t            state, stateNxt;
  logic [CNT_W-1:0]  sweepCnt, sweepCntNxt;
  logic              regWriteNxt;
  logic [ADDR_W-1:0] writeRegNxt;
  logic [DATA_W-1:0] writeDataNxt;
  logic              initDoneNxt;
  logic [1:0]        arbValid;
  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  assign arbValid = (state == RUN) ? req_valid : 2'b00;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .valid   (arbValid),
    .advance (state == RUN),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & req_ready);
  assign selAddr   = req_ready[1] ? req_addr1 : req_addr0;
  assign selData   = req_ready[1] ? req_data1 : req_data0;
  assign dbgState  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= INIT;
      sweepCnt      <= CNT_W'(1);
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      init_done     <= 1'b0;
    end else begin
      state         <= stateNxt;
      sweepCnt      <= sweepCntNxt;
      RegWrite      <= regWriteNxt;
      WriteRegister <= writeRegNxt;
      WriteData     <= writeDataNxt;
      init_done     <= initDoneNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    if ((state == INIT) && (sweepCnt > LAST_REG)) begin
      stateNxt = RUN;
    end
  end

  always_comb begin
    sweepCntNxt  = sweepCnt;
    regWriteNxt  = 1'b0;
    writeRegNxt  = WriteRegister;
    writeDataNxt = WriteData;
    initDoneNxt  = init_done;
    case (state)
      INIT: begin
        if (sweepCnt <= LAST_REG) begin
          regWriteNxt  = 1'b1;
          writeRegNxt  = sweepCnt[ADDR_W-1:0];
          writeDataNxt = '0;
          sweepCntNxt  = sweepCnt + 1'b1;
        end else begin
          initDoneNxt = 1'b1;
        end
      end
      RUN: begin
        // Register 0 is hardwired zero: the handshake completes but nothing is written.
        if (xfer) begin
          regWriteNxt  = (selAddr != '0);
          writeRegNxt  = selAddr;
          writeDataNxt = selData;
        end
      end
      default: begin
        regWriteNxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a per-cycle behavioural model
// and a register-file model fed from the DUT write port.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req_valid = 2'b00;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [DW-1:0] req_data0 = '0;
  logic [DW-1:0] req_data1 = '0;
  logic [1:0]    req_ready;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          RegWrite;
  logic          init_done;
  state_t        dbgState;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .req_ready     (req_ready),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .init_done     (init_done),
    .dbgState      (dbgState)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- register file fed by the DUT ----------------
  logic [DW-1:0] rf [NR];
  initial begin
    for (int i = 0; i < NR; i++) rf[i] = $urandom | 32'h1;
  end
  always @(posedge clk) begin
    if (RegWrite && (WriteRegister != '0)) rf[WriteRegister] <= WriteData;
  end
  function automatic logic [DW-1:0] rd(input int a);
    return (a == 0) ? '0 : rf[a];
  endfunction

  // ---------------- behavioural model ----------------
  // m_edges counts rising edges since reset release: edges 1..31 sweep,
  // edge 32 ends INIT, after that requests are served.
  int            m_edges = 0;
  logic          m_ptr   = 1'b0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_wr    = '0;
  logic [DW-1:0] m_wd    = '0;

  function automatic logic [1:0] exp_ready();
    if (m_edges < NR) return 2'b00;
    if (req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [1:0]    g;
    logic [AW-1:0] a;
    if (!reset) begin
      m_edges = 0;
      m_ptr   = 1'b0;
      m_we    = 1'b0;
      m_wr    = '0;
      m_wd    = '0;
    end else begin
      g = exp_ready();
      if (m_edges < NR - 1) begin
        m_we = 1'b1;
        m_wr = AW'(m_edges + 1);
        m_wd = '0;
      end else if (g != 2'b00) begin
        a    = g[1] ? req_addr1 : req_addr0;
        m_we = (a != '0);
        m_wr = a;
        m_wd = g[1] ? req_data1 : req_data0;
        m_ptr = g[0];
      end else begin
        m_we = 1'b0;
      end
      m_edges++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("ready", req_ready, exp_ready());
    check("regwrite", RegWrite, m_we);
    check("init_done", init_done, (m_edges >= NR));
    check("state", dbgState, (m_edges >= NR) ? RUN : INIT);
    if (!reset || m_we) begin
      check("write_reg", WriteRegister, m_wr);
      check("write_data", WriteData, m_wd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check(input string tag);
    bit reg_ok;
    bit done_low;
    reg_ok   = 1'b1;
    done_low = 1'b1;
    next_cycle();
    check({tag, "_first_reg"}, {RegWrite, WriteRegister}, {1'b1, 5'd1});
    for (int k = 2; k <= NR - 1; k++) begin
      next_cycle();
      if (!(RegWrite && WriteRegister == AW'(k) && WriteData == '0)) reg_ok = 1'b0;
      if (init_done) done_low = 1'b0;
    end
    check({tag, "_sweep_seq"}, reg_ok, 1'b1);
    check({tag, "_done_low"}, done_low, 1'b1);
    check({tag, "_last_reg"}, WriteRegister, 5'd31);
    next_cycle();
    check({tag, "_done_high"}, init_done, 1'b1);
    check({tag, "_idle_we"}, RegWrite, 1'b0);
  endtask

  // ---------------- directed test ----------------
  initial begin
    logic [1:0] g [4];
    bit found;

    repeat (2) @(negedge clk);
    #1;
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_wreg", WriteRegister, 5'd0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_done", init_done, 1'b0);
    check("rst_ready", req_ready, 2'b00);

    @(negedge clk);
    reset = 1'b1;
    sweep_check("sweep1");
    for (int r = 0; r < NR; r++) check("rf_zero", rd(r), 32'h0);

    // lone requester 0
    req_valid = 2'b01; req_addr0 = 5'd5; req_data0 = 32'hDEADBEEF;
    #1;
    check("single_ready", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    check("single_write", {RegWrite, WriteRegister}, {1'b1, 5'd5});
    check("single_data", WriteData, 32'hDEADBEEF);
    next_cycle();
    check("single_rf", rd(5), 32'hDEADBEEF);
    check("single_idle", RegWrite, 1'b0);

    // requester 1 targets the zero register
    req_valid = 2'b10; req_addr1 = 5'd0; req_data1 = 32'hA0;
    #1;
    check("zero_ready", req_ready, 2'b10);
    next_cycle();
    req_valid = 2'b00;
    check("zero_no_write", RegWrite, 1'b0);
    next_cycle();
    check("zero_rf", rd(0), 32'h0);

    // both valid for four cycles
    req_valid = 2'b11;
    req_addr0 = 5'd3; req_data0 = 32'h11;
    req_addr1 = 5'd4; req_data1 = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      g[i] = req_ready;
      next_cycle();
      check("rr_write", {RegWrite, WriteRegister}, {1'b1, (i % 2 == 1) ? 5'd4 : 5'd3});
    end
    req_valid = 2'b00;
    check("rr_grants", {g[0], g[1], g[2], g[3]}, 8'b01_10_01_10);
    next_cycle();
    check("rr_rf3", rd(3), 32'h11);
    check("rr_rf4", rd(4), 32'h22);

    // same target from both requesters
    req_valid = 2'b11;
    req_addr0 = 5'd7; req_data0 = 32'h1;
    req_addr1 = 5'd7; req_data1 = 32'h2;
    #1;
    check("same_first", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b10;
    check("same_data1", WriteData, 32'h1);
    #1;
    check("same_second", req_ready, 2'b10);
    next_cycle();
    req_valid = 2'b00;
    check("same_data2", {WriteRegister, WriteData}, {5'd7, 32'h2});
    next_cycle();
    check("same_rf7", rd(7), 32'h2);

    // reset in the middle of a sweep
    reset = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      next_cycle();
      if (RegWrite && WriteRegister == 5'd10) found = 1'b1;
    end
    check("mid_reach_reg10", found, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_outputs", {RegWrite, WriteRegister, WriteData, init_done, req_ready},
          {1'b0, 5'd0, 32'h0, 1'b0, 2'b00});
    @(negedge clk);
    reset = 1'b1;
    sweep_check("sweep2");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of register data.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (2**ADDR_W registers, register 0 hardwired zero).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid[1:0]  input  2  per-requester write request.
REQ-006 SHALL have ports req_addr0, req_addr1  input  ADDR_W each  target register.
REQ-007 SHALL have ports req_data0, req_data1  input  DATA_W each  write value.
REQ-008 SHALL have port req_ready[1:0]  output  2  per-requester acceptance; transfer when valid and ready high in the same cycle.
REQ-009 SHALL have port WriteRegister  output  ADDR_W  register-file write index.
REQ-010 SHALL have port WriteData  output  DATA_W  register-file write data.
REQ-011 SHALL have port RegWrite  output  1  register-file write enable.
REQ-012 SHALL have port init_done  output  1  high once the post-reset clear sweep has finished.

Function
REQ-013 SHALL implement states INIT and RUN; reset enters INIT.
REQ-014 In INIT, SHALL drive RegWrite=1, WriteData=0, WriteRegister=sweep counter, counter from 1 to 2**ADDR_W-1 incrementing each cycle (31 cycles at default).
REQ-015 SHALL transition INIT->RUN in the cycle after the write to the last register; init_done rises in that same transition and stays high until reset.
REQ-016 In INIT, req_ready SHALL be 2'b00; no request accepted.
REQ-017 In RUN, SHALL grant at most one requester per cycle; req_ready is combinational from req_valid and priority pointer.
REQ-018 Single valid requester SHALL be granted immediately (req_ready high same cycle).
REQ-019 Both valid: SHALL grant requester indicated by priority pointer; pointer resets to 0 and, after each grant, points to the non-granted requester (round-robin).
REQ-020 Ungranted requester SHALL hold valid/addr/data stable; arbiter needs no storage for it.
REQ-021 Accepted request SHALL appear registered on WriteRegister/WriteData with RegWrite=1 in the following cycle (latency 1); sustained throughput one write per cycle.
REQ-022 Accepted request with addr 0 SHALL complete the handshake but produce RegWrite=0 the following cycle.
REQ-023 Cycle with no transfer SHALL produce RegWrite=0 the following cycle; WriteRegister/WriteData hold last value.
REQ-024 Same target address from both requesters SHALL be serialized in grant order; later grant wins in the register file.
REQ-025 Priority pointer SHALL not change in cycles without a grant.

Reset
REQ-026 Reset assertion SHALL immediately (asynchronously) force state INIT, sweep counter 1, priority pointer 0, init_done 0, RegWrite 0, WriteRegister 0, WriteData 0, req_ready 0.
REQ-027 Reset asserted mid-sweep or mid-RUN SHALL abandon all activity; after deassertion the full sweep restarts at register 1.
REQ-028 First INIT write (RegWrite=1, register 1) SHALL occur on the first rising clk edge after reset deassertion.

Structure
REQ-029 Shared package regfile_pkg SHALL hold the state enum (INIT, RUN), DATA_W/ADDR_W defaults and the register-count constant.
REQ-030 Two-input round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs valid[1:0], advance; output grant[1:0]; internal pointer).
REQ-031 Block SHALL connect directly to the register-file write port with no added glue.

Verification
REQ-032 Reset release, no requests -> RegWrite=1 for 31 consecutive cycles, WriteRegister 1..31, WriteData 0; init_done high cycle 32; regfile reads all zero.
REQ-033 RUN, req_valid=01, addr0=5, data0=32'hDEADBEEF -> ready0=1 same cycle; next cycle RegWrite=1, WriteRegister=5; read of r5 returns DEADBEEF.
REQ-034 RUN, both valid continuously for 4 cycles (addr0=3 data 32'h11, addr1=4 data 32'h22) -> grants 0,1,0,1; RegWrite high 4 consecutive cycles.
REQ-035 RUN, requester 1 writes addr 0 data 32'hA0 -> handshake completes, RegWrite=0 next cycle, r0 reads 0.
REQ-036 Reset asserted at sweep register 10 -> outputs zero immediately; after release sweep restarts at 1, init_done low until full 31-cycle sweep completes.
REQ-037 Both requesters target addr 7 (data 32'h1 req0, 32'h2 req1), pointer 0 -> r7 ends 32'h2.
